// File: rtl/lcd_disp_seq.sv
// lcd_disp_seq: start-up and run-time sequencer for the SD card -> DDR3
// frame buffer -> 480x272 LCD path, running in the pixel clock domain.
// The frame-buffer reader stays halted and the panel stays blanked until
// DDR3 calibration is done and one full image has been written. The
// sequencer then waits a few frames before releasing the display. It
// tracks image updates, and it blanks on a write timeout or when
// calibration is lost.
//
// Ports:
//   video_clk   in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   calib_done  in   DDR3 init_calib_complete (async level)
//   wr_req      in   SD image write active (sd_card_clk domain level)
//   syn_vs      in   timing generator vertical sync, active high
//   rd_halt     out  frame-buffer read halt (1 = halt)
//   wr_halt     out  frame-buffer write halt (1 = halt)
//   blank       out  force LCD RGB to zero
//   disp_on     out  backlight / panel enable
//   img_cnt     out  completed images written, saturating
//   state       out  current state encoding (debug)
//   err         out  sticky write-timeout flag
//
// Handshake note: there is no valid/ready pair here. Every input is a
// level signal. An event is taken only on the cycle its synchronised edge
// is seen, and every output is a registered level.
module lcd_disp_seq #(
  parameter int SETTLE_FRAMES     = 2,
  parameter int WR_TIMEOUT_FRAMES = 255,
  parameter int CNT_W             = 8
) (
  input  logic             video_clk,
  input  logic             rst_n,
  input  logic             calib_done,
  input  logic             wr_req,
  input  logic             syn_vs,
  output logic             rd_halt,
  output logic             wr_halt,
  output logic             blank,
  output logic             disp_on,
  output logic [CNT_W-1:0] img_cnt,
  output logic [2:0]       state,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_IMG = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_UPDATE   = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_calib_m, r_calib_s;
  logic             r_wr_m, r_wr_s, r_wr_d;
  logic             r_vs_d;
  logic [7:0]       r_to_cnt;
  logic [3:0]       r_set_cnt;
  logic [CNT_W-1:0] r_img_cnt;
  logic             r_rd_halt, r_wr_halt, r_blank, r_disp_on, r_err;

  logic             w_wr_rise, w_wr_fall, w_vs_rise;
  logic [7:0]       w_to_next;
  logic [4:0]       w_set_next;
  logic             w_to_hit, w_set_hit, w_img_inc;
  logic             w_rd_halt, w_wr_halt, w_blank, w_disp_on;

  // Two-flop synchronisers, plus the delay flops used for edge detection.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_calib_m <= 1'b0;
      r_calib_s <= 1'b0;
      r_wr_m    <= 1'b0;
      r_wr_s    <= 1'b0;
      r_wr_d    <= 1'b0;
      r_vs_d    <= 1'b0;
    end else begin
      r_calib_m <= calib_done;
      r_calib_s <= r_calib_m;
      r_wr_m    <= wr_req;
      r_wr_s    <= r_wr_m;
      r_wr_d    <= r_wr_s;
      r_vs_d    <= syn_vs;
    end
  end

  assign w_wr_rise  = r_wr_s & ~r_wr_d;
  assign w_wr_fall  = ~r_wr_s & r_wr_d;
  assign w_vs_rise  = syn_vs & ~r_vs_d;

  // Both compares use the value the counter would take on this vs_rise.
  // A transition therefore lands on the same cycle as the frame edge
  // that completes the count.
  assign w_to_next  = (r_to_cnt == 8'hFF) ? 8'hFF : r_to_cnt + 8'd1;
  assign w_to_hit   = w_vs_rise & r_wr_s & (w_to_next >= 8'(WR_TIMEOUT_FRAMES));
  assign w_set_next = {1'b0, r_set_cnt} + 5'd1;
  assign w_set_hit  = w_vs_rise & (w_set_next >= 5'(SETTLE_FRAMES));

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Calibration loss overrides everything, including an image completion
  // on the same cycle. In WAIT_IMG and UPDATE a write end beats a timeout.
  always_comb begin
    w_next    = r_state;
    w_img_inc = 1'b0;
    if (r_state != ST_IDLE && !r_calib_s) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (r_calib_s) w_next = ST_WAIT_IMG;
        ST_WAIT_IMG: begin
          if (w_wr_fall) begin
            w_img_inc = 1'b1;
            w_next    = ST_SETTLE;
          end else if (w_to_hit) begin
            w_next = ST_ERR;
          end
        end
        ST_SETTLE:   if (w_set_hit) w_next = ST_RUN;
        ST_RUN:      if (w_wr_rise) w_next = ST_UPDATE;
        ST_UPDATE: begin
          if (w_wr_fall) begin
            w_img_inc = 1'b1;
            w_next    = ST_RUN;
          end else if (w_to_hit) begin
            w_next = ST_ERR;
          end
        end
        ST_ERR:      if (!r_wr_s && w_vs_rise) w_next = ST_WAIT_IMG;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  // The outputs are decoded from the next state and then registered, so
  // they change on the same edge as the state. The only path that clears
  // blank is SETTLE -> RUN, and that path fires only on a vs_rise cycle.
  // SETTLE keeps the write side halted, because a write there would not
  // be tracked.
  always_comb begin
    w_rd_halt = 1'b1;
    w_wr_halt = 1'b1;
    w_blank   = 1'b1;
    w_disp_on = 1'b0;
    case (w_next)
      ST_WAIT_IMG: w_wr_halt = 1'b0;
      ST_SETTLE:   w_rd_halt = 1'b0;
      ST_RUN, ST_UPDATE: begin
        w_rd_halt = 1'b0;
        w_wr_halt = 1'b0;
        w_blank   = 1'b0;
        w_disp_on = 1'b1;
      end
      ST_ERR: begin
        w_rd_halt = 1'b0;
        w_disp_on = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_halt <= 1'b1;
      r_wr_halt <= 1'b1;
      r_blank   <= 1'b1;
      r_disp_on <= 1'b0;
      r_err     <= 1'b0;
      r_img_cnt <= '0;
      r_to_cnt  <= 8'd0;
      r_set_cnt <= 4'd0;
    end else begin
      r_rd_halt <= w_rd_halt;
      r_wr_halt <= w_wr_halt;
      r_blank   <= w_blank;
      r_disp_on <= w_disp_on;
      r_err     <= r_err | (w_next == ST_ERR);
      if (w_img_inc && (r_img_cnt != {CNT_W{1'b1}})) r_img_cnt <= r_img_cnt + 1'b1;
      // The timeout counter counts frames only while a write is pending.
      // It restarts on every write start and is cleared in all other states.
      if ((r_state == ST_WAIT_IMG || r_state == ST_UPDATE) && !w_wr_rise) begin
        if (w_vs_rise && r_wr_s) r_to_cnt <= w_to_next;
      end else begin
        r_to_cnt <= 8'd0;
      end
      if (r_state != ST_SETTLE)  r_set_cnt <= 4'd0;
      else if (w_vs_rise)        r_set_cnt <= w_set_next[3:0];
    end
  end

  assign rd_halt = r_rd_halt;
  assign wr_halt = r_wr_halt;
  assign blank   = r_blank;
  assign disp_on = r_disp_on;
  assign img_cnt = r_img_cnt;
  assign err     = r_err;
  assign state   = r_state;

endmodule

// File: tb/tb_lcd_disp_seq.sv
module tb_lcd_disp_seq;

  localparam int W = 16;

  logic       video_clk = 1'b0;
  logic       rst_n;
  logic       calib_done;
  logic       wr_req;
  logic       syn_vs;
  logic       rd_halt, wr_halt, blank, disp_on, err;
  logic [7:0] img_cnt;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [2:0]   prev_state = 3'd0;

  lcd_disp_seq #(
    .SETTLE_FRAMES    (2),
    .WR_TIMEOUT_FRAMES(4),
    .CNT_W            (8)
  ) dut (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .calib_done(calib_done),
    .wr_req    (wr_req),
    .syn_vs    (syn_vs),
    .rd_halt   (rd_halt),
    .wr_halt   (wr_halt),
    .blank     (blank),
    .disp_on   (disp_on),
    .img_cnt   (img_cnt),
    .state     (state),
    .err       (err)
  );

  // clock / watchdog
  always #5 video_clk = ~video_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // {state, rd_halt, wr_halt, blank, disp_on, err, img_cnt}
  function automatic logic [W-1:0] snap(input logic [2:0] s, input logic rd, input logic wr,
                                        input logic bl, input logic dp, input logic er,
                                        input logic [7:0] ic);
    return {s, rd, wr, bl, dp, er, ic};
  endfunction

  function automatic logic [W-1:0] snap_dut();
    return {state, rd_halt, wr_halt, blank, disp_on, err, img_cnt};
  endfunction

  // monitor: every state change must match the next expected snapshot
  always @(negedge video_clk) begin
    if (state !== prev_state) begin
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transition: got %h expected no change from state %0d", snap_dut(), prev_state);
      end else begin
        e = exp_q.pop_front();
        if (snap_dut() !== e) begin
          errors++;
          $display("FAIL transition: got %h expected %h", snap_dut(), e);
        end
      end
      prev_state = state;
    end
  end

  // driver tasks (inputs change 1 time unit after posedge)
  task automatic tick(input int n);
    repeat (n) @(posedge video_clk);
    #1;
  endtask

  task automatic frame();
    syn_vs = 1'b1;
    tick(2);
    syn_vs = 1'b0;
    tick(8);
  endtask

  task automatic check_now(input string name, input logic [W-1:0] e);
    checks++;
    if (snap_dut() !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, snap_dut(), e);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge video_clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected transitions outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
    @(posedge video_clk);
    #1;
  endtask

  // directed stimulus
  initial begin
    calib_done = 1'b0;
    wr_req     = 1'b0;
    syn_vs     = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;

    // reset held, wr_req toggling
    for (int i = 0; i < 6; i++) begin
      @(posedge video_clk); #1;
      wr_req = ~wr_req;
      if (i % 2 == 1) check_now("reset_hold", snap(3'd0, 1, 1, 1, 0, 0, 8'd0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_req = ~wr_req;
      tick(1);
    end
    wr_req = 1'b0;
    tick(4);
    check_now("idle_no_calib", snap(3'd0, 1, 1, 1, 0, 0, 8'd0));

    // calibration completes
    exp_q.push_back(snap(3'd1, 1, 0, 1, 0, 0, 8'd0));
    calib_done = 1'b1;
    wait_drain("calib_up", 4);

    // first image
    wr_req = 1'b1;
    tick(5);
    repeat (3) frame();
    exp_q.push_back(snap(3'd2, 0, 1, 1, 0, 0, 8'd1));
    wr_req = 1'b0;
    wait_drain("first_img", 6);

    // settle: first vs_rise keeps blank, second unblanks on the next cycle
    frame();
    check_now("settle_1", snap(3'd2, 0, 1, 1, 0, 0, 8'd1));
    exp_q.push_back(snap(3'd3, 0, 0, 0, 1, 0, 8'd1));
    syn_vs = 1'b1;
    @(negedge video_clk);
    check_now("pre_unblank", snap(3'd2, 0, 1, 1, 0, 0, 8'd1));
    @(negedge video_clk);
    check_now("unblank_edge", snap(3'd3, 0, 0, 0, 1, 0, 8'd1));
    @(posedge video_clk); #1;
    syn_vs = 1'b0;
    tick(8);
    wait_drain("run_entry", 1);

    // update spanning 3 frames
    exp_q.push_back(snap(3'd4, 0, 0, 0, 1, 0, 8'd1));
    wr_req = 1'b1;
    wait_drain("upd_enter", 5);
    repeat (3) frame();
    exp_q.push_back(snap(3'd3, 0, 0, 0, 1, 0, 8'd2));
    wr_req = 1'b0;
    wait_drain("upd_done", 5);

    // write timeout in UPDATE
    exp_q.push_back(snap(3'd4, 0, 0, 0, 1, 0, 8'd2));
    wr_req = 1'b1;
    wait_drain("upd2_enter", 5);
    exp_q.push_back(snap(3'd5, 0, 1, 1, 1, 1, 8'd2));
    repeat (5) frame();
    wait_drain("timeout", 1);
    exp_q.push_back(snap(3'd1, 1, 0, 1, 0, 1, 8'd2));
    wr_req = 1'b0;
    tick(5);
    check_now("err_hold", snap(3'd5, 0, 1, 1, 1, 1, 8'd2));
    frame();
    wait_drain("err_exit", 1);

    // new image after error, err stays set
    wr_req = 1'b1;
    tick(5);
    repeat (2) frame();
    exp_q.push_back(snap(3'd2, 0, 1, 1, 0, 1, 8'd3));
    wr_req = 1'b0;
    wait_drain("img3", 6);
    exp_q.push_back(snap(3'd3, 0, 0, 0, 1, 1, 8'd3));
    repeat (2) frame();
    wait_drain("run3", 1);

    // calibration loss in RUN
    exp_q.push_back(snap(3'd0, 1, 1, 1, 0, 1, 8'd3));
    calib_done = 1'b0;
    wait_drain("calib_loss", 4);

    // recovery
    exp_q.push_back(snap(3'd1, 1, 0, 1, 0, 1, 8'd3));
    calib_done = 1'b1;
    wait_drain("recal", 4);
    wr_req = 1'b1;
    tick(5);
    frame();
    exp_q.push_back(snap(3'd2, 0, 1, 1, 0, 1, 8'd4));
    wr_req = 1'b0;
    wait_drain("img4", 6);
    exp_q.push_back(snap(3'd3, 0, 0, 0, 1, 1, 8'd4));
    repeat (2) frame();
    wait_drain("run4", 1);

    // wr_req fall coincident with calibration loss: image not counted
    exp_q.push_back(snap(3'd4, 0, 0, 0, 1, 1, 8'd4));
    wr_req = 1'b1;
    wait_drain("upd3_enter", 5);
    frame();
    exp_q.push_back(snap(3'd0, 1, 1, 1, 0, 1, 8'd4));
    wr_req     = 1'b0;
    calib_done = 1'b0;
    wait_drain("fall_calib_loss", 4);
    tick(5);
    check_now("cnt_unchanged", snap(3'd0, 1, 1, 1, 0, 1, 8'd4));

    // async reset mid-SETTLE
    exp_q.push_back(snap(3'd1, 1, 0, 1, 0, 1, 8'd4));
    calib_done = 1'b1;
    wait_drain("recal2", 4);
    wr_req = 1'b1;
    tick(5);
    exp_q.push_back(snap(3'd2, 0, 1, 1, 0, 1, 8'd5));
    wr_req = 1'b0;
    wait_drain("img5", 6);
    frame();
    exp_q.push_back(snap(3'd0, 1, 1, 1, 0, 0, 8'd0));
    calib_done = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_now("async_rst", snap(3'd0, 1, 1, 1, 0, 0, 8'd0));
    wait_drain("rst_mon", 2);
    rst_n = 1'b1;
    tick(6);

    // final report
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
